mem_mmio: RTL and testbench



---
 rtl/mem_mmio_pkg.sv | 31 +++
 rtl/mmio_out_chan.sv | 40 ++++
 rtl/mem_mmio.sv | 91 +++++++++
 tb/tb_mem_mmio.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_mmio_pkg.sv
// Shared types and address decode for the RAM + memory-mapped output block.
package mem_mmio_pkg;

  localparam int unsigned OUT_BASE_DEFAULT = 100;

  typedef enum logic [1:0] {REG_RAM, REG_OUT, REG_STATUS, REG_NONE} region_t;

  typedef struct packed {
    region_t     region;
    logic [31:0] ch;
  } dec_t;

  // MMIO and STATUS win over RAM so overlapping RAM words are shadowed.
  function automatic dec_t decode(input logic [31:0] a, input int unsigned base,
                                  input int unsigned num, input int unsigned status,
                                  input int unsigned depth);
    dec_t d;
    d.region = REG_NONE;
    d.ch     = '0;
    if (a >= base && a < base + num) begin
      d.region = REG_OUT;
      d.ch     = a - base;
    end else if (a == status) begin
      d.region = REG_STATUS;
    end else if (a < depth) begin
      d.region = REG_RAM;
    end
    return d;
  endfunction

endpackage

// File: rtl/mmio_out_chan.sv
// One output channel: holding register with valid/ready handshake and drop detection.
module mmio_out_chan #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ovf_set
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              w_pop;
  logic              w_accept;

  assign w_pop     = r_valid & i_ready;
  // A pop in the same cycle frees the slot, so streaming needs no bubble.
  assign w_accept  = i_load & (~r_valid | w_pop);
  assign o_ovf_set = i_load & r_valid & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= i_din;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/mem_mmio.sv
// CPU-side synchronous RAM with NUM_OUT memory-mapped output channels and a W1C status register.
module mem_mmio
  import mem_mmio_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int NUM_OUT  = 2,
  parameter int OUT_BASE = OUT_BASE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  input  logic                      we,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT-1:0]        ovf
);

  localparam int STATUS_ADDR = OUT_BASE + NUM_OUT;
  localparam int MEM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  dec_t                            w_dec;
  logic [MEM_AW-1:0]               w_mem_idx;
  logic [NUM_OUT-1:0]              w_load;
  logic [NUM_OUT-1:0]              w_ovf_set;
  logic [NUM_OUT-1:0][DATA_W-1:0]  w_hold;
  logic [DATA_W-1:0]               w_rd;
  logic [DATA_W-1:0]               r_dout;
  logic [NUM_OUT-1:0]              r_ovf;

  assign w_dec     = decode(32'(addr), OUT_BASE, NUM_OUT, STATUS_ADDR, DEPTH);
  assign w_mem_idx = addr[MEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (we && w_dec.region == REG_RAM) mem[w_mem_idx] <= din;
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
    assign w_load[g] = we && w_dec.region == REG_OUT && w_dec.ch == 32'(g);
    mmio_out_chan #(.DATA_W(DATA_W)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_load[g]),
      .i_din     (din),
      .i_ready   (out_ready[g]),
      .o_data    (w_hold[g]),
      .o_valid   (out_valid[g]),
      .o_ovf_set (w_ovf_set[g])
    );
  end

  // Sets are OR'd in after the clear so a coincident drop keeps the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else if (we && w_dec.region == REG_STATUS) begin
      r_ovf <= (r_ovf & ~din[NUM_OUT-1:0]) | w_ovf_set;
    end else begin
      r_ovf <= r_ovf | w_ovf_set;
    end
  end

  always_comb begin
    w_rd = '0;
    case (w_dec.region)
      REG_RAM:    w_rd = mem[w_mem_idx];
      REG_OUT: begin
        for (int k = 0; k < NUM_OUT; k++)
          if (w_dec.ch == 32'(k)) w_rd = w_hold[k];
      end
      REG_STATUS: w_rd[NUM_OUT-1:0] = r_ovf;
      default:    w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dout <= '0;
    else        r_dout <= w_rd;
  end

  assign dout     = r_dout;
  assign ovf      = r_ovf;
  assign out_data = w_hold;

endmodule

// File: tb/tb_mem_mmio.sv
// Bench for mem_mmio: directed vector table, corner sequences, then random traffic against a reference model.
module tb_mem_mmio;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        we;
  logic [15:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [1:0]  ovf;

  mem_mmio dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .dout(dout), .we(we),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  logic [7:0] m_hold [2];
  logic [1:0] m_vld;
  logic [1:0] m_ovf;
  logic [7:0] m_dout;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic [1:0]  r;
    logic [7:0]  e_dout;
    logic [1:0]  e_vld;
    logic [1:0]  e_ovf;
    logic [15:0] e_data;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = '0;
    m_ovf = '0;
    m_hold[0] = '0;
    m_hold[1] = '0;
    m_dout = '0;
  endtask

  // Drive one cycle and advance the model; outputs are sampled 1ns after the edge.
  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w, input logic [1:0] r);
    int ai;
    logic pop, ld;
    addr = a; din = d; we = w; out_ready = r;
    ai = int'(a);
    if (ai >= 100 && ai < 102) m_dout = m_hold[ai-100];
    else if (ai == 102)        m_dout = {6'b0, m_ovf};
    else if (ai < 256)         m_dout = m_mem[ai];
    else                       m_dout = 8'h00;
    if (w && ai == 102) m_ovf = m_ovf & ~d[1:0];
    for (int k = 0; k < 2; k++) begin
      pop = m_vld[k] && r[k];
      ld  = w && (ai == 100 + k);
      if (ld && (!m_vld[k] || pop)) begin
        m_hold[k] = d;
        m_vld[k]  = 1'b1;
      end else if (ld) begin
        m_ovf[k] = 1'b1;
      end else if (pop) begin
        m_vld[k] = 1'b0;
      end
    end
    if (w && ai < 256 && (ai < 100 || ai > 102)) m_mem[ai] = d;
    @(posedge clk);
    #1;
  endtask

  task automatic mchk(input int i);
    chk($sformatf("rnd%0d dout", i), 32'(dout), 32'(m_dout));
    chk($sformatf("rnd%0d valid", i), 32'(out_valid), 32'(m_vld));
    chk($sformatf("rnd%0d ovf", i), 32'(ovf), 32'(m_ovf));
    chk($sformatf("rnd%0d data", i), 32'(out_data), 32'({m_hold[1], m_hold[0]}));
  endtask

  logic [7:0] shadow0;
  int         sel;
  logic [15:0] ra;

  initial begin
    rst_n = 1'b0; addr = '0; din = '0; we = 1'b0; out_ready = '0;
    model_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    #12;
    chk("reset dout", 32'(dout), 32'h0);
    chk("reset valid", 32'(out_valid), 32'h0);
    chk("reset data", 32'(out_data), 32'h0);
    chk("reset ovf", 32'(ovf), 32'h0);
    shadow0 = dut.mem[100];
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload RAM through the bus, avoiding the MMIO/status window
    for (int i = 0; i < 256; i++)
      if (i < 100 || i > 102) step(16'(i), 8'(i) ^ 8'hA5, 1'b1, 2'b00);

    vt[0]  = '{16'd7,   8'h5A, 1'b1, 2'b00, 8'hA2, 2'b00, 2'b00, 16'h0000};
    vt[1]  = '{16'd7,   8'h00, 1'b0, 2'b00, 8'h5A, 2'b00, 2'b00, 16'h0000};
    vt[2]  = '{16'd300, 8'h00, 1'b0, 2'b00, 8'h00, 2'b00, 2'b00, 16'h0000};
    vt[3]  = '{16'd100, 8'h11, 1'b1, 2'b00, 8'h00, 2'b01, 2'b00, 16'h0011};
    vt[4]  = '{16'd0,   8'h00, 1'b0, 2'b01, 8'hA5, 2'b00, 2'b00, 16'h0011};
    vt[5]  = '{16'd100, 8'h11, 1'b1, 2'b00, 8'h11, 2'b01, 2'b00, 16'h0011};
    vt[6]  = '{16'd100, 8'h22, 1'b1, 2'b00, 8'h11, 2'b01, 2'b01, 16'h0011};
    vt[7]  = '{16'd102, 8'h00, 1'b0, 2'b00, 8'h01, 2'b01, 2'b01, 16'h0011};
    vt[8]  = '{16'd102, 8'h01, 1'b1, 2'b00, 8'h01, 2'b01, 2'b00, 16'h0011};
    vt[9]  = '{16'd102, 8'h00, 1'b0, 2'b00, 8'h00, 2'b01, 2'b00, 16'h0011};
    vt[10] = '{16'd0,   8'h00, 1'b0, 2'b01, 8'hA5, 2'b00, 2'b00, 16'h0011};
    vt[11] = '{16'd101, 8'h01, 1'b1, 2'b10, 8'h00, 2'b10, 2'b00, 16'h0111};
    vt[12] = '{16'd101, 8'h02, 1'b1, 2'b10, 8'h01, 2'b10, 2'b00, 16'h0211};
    vt[13] = '{16'd101, 8'h03, 1'b1, 2'b10, 8'h02, 2'b10, 2'b00, 16'h0311};
    vt[14] = '{16'd101, 8'h00, 1'b0, 2'b10, 8'h03, 2'b00, 2'b00, 16'h0311};
    vt[15] = '{16'd500, 8'hFF, 1'b1, 2'b00, 8'h00, 2'b00, 2'b00, 16'h0311};
    vt[16] = '{16'd500, 8'h00, 1'b0, 2'b00, 8'h00, 2'b00, 2'b00, 16'h0311};

    for (int i = 0; i < 17; i++) begin
      step(vt[i].a, vt[i].d, vt[i].w, vt[i].r);
      chk($sformatf("vec%0d dout", i), 32'(dout), 32'(vt[i].e_dout));
      chk($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vt[i].e_vld));
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vt[i].e_ovf));
      chk($sformatf("vec%0d data", i), 32'(out_data), 32'(vt[i].e_data));
    end

    // Clear and drop in adjacent cycles: the later drop must leave the flag set
    step(16'd100, 8'h33, 1'b1, 2'b00);
    step(16'd100, 8'h44, 1'b1, 2'b00);
    chk("coll ovf set", 32'(ovf), 32'h1);
    step(16'd102, 8'h01, 1'b1, 2'b00);
    chk("coll ovf clr", 32'(ovf), 32'h0);
    step(16'd100, 8'h55, 1'b1, 2'b00);
    chk("coll ovf final", 32'(ovf), 32'h1);
    chk("coll data kept", 32'(out_data[7:0]), 32'h33);
    chk("shadow ram 100", 32'(dut.mem[100]), 32'(shadow0));

    // Asynchronous reset between edges with both channels full
    step(16'd101, 8'h66, 1'b1, 2'b00);
    chk("pre-rst valid", 32'(out_valid), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", 32'(out_valid), 32'h0);
    chk("async rst ovf", 32'(ovf), 32'h0);
    chk("async rst data", 32'(out_data), 32'h0);
    chk("async rst dout", 32'(dout), 32'h0);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(16'd7, 8'h00, 1'b0, 2'b00);
    chk("ram kept after rst", 32'(dout), 32'h5A);

    // Random traffic weighted toward the MMIO window
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)       ra = 16'($urandom_range(0, 255));
      else if (sel < 8)  ra = 16'(100 + $urandom_range(0, 2));
      else if (sel == 8) ra = 16'($urandom_range(256, 1000));
      else               ra = 16'd102;
      step(ra, 8'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      mchk(i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
